instr_mem: RTL and testbench
============================

# instr_mem

Parametrised, loadable instruction memory for the SCIC CPU; it replaces the fixed 32-word program store. After reset it clears itself to NOPs. A streaming loader handshake writes a program from address 0, and the fetch port gives registered reads with a valid flag. It sits between the program-load source (testbench or host I/O controller) and the CPU fetch stage.

## Interface
- DATA_WIDTH, 32, instruction word width (opcode in the top 4 bits)
- ADDR_WIDTH, 5, word address width; DEPTH = 2**ADDR_WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- chip_select  in  1  fetch enable
- address  in  ADDR_WIDTH  fetch word address
- data_out  out  DATA_WIDTH  fetched instruction (registered)
- data_valid  out  1  data_out holds a real fetch result
- load_start  in  1  begin a load (sampled in IDLE only)
- load_len  in  ADDR_WIDTH+1  number of words to load
- load_data  in  DATA_WIDTH  word to write
- load_valid  in  1  load_data valid
- load_ready  out  1  instr_mem accepts load_data this cycle
- load_done  out  1  one-cycle pulse at load completion
- busy  out  1  state is not IDLE

## Operation
- States: CLEAR, IDLE, LOAD.
- Internal registers: pointer `ptr` (ADDR_WIDTH bits) and remaining-count `rem` (ADDR_WIDTH+1 bits).
- **Reset:**
  - Enter CLEAR with ptr=0.
  - Outputs: data_out=0, data_valid=0, load_ready=0, load_done=0, busy=1.
  - Reset mid-LOAD aborts the load; no load_done pulse is issued.
- **CLEAR:**
  - Writes NOP (0) to mem[ptr] each cycle and increments ptr.
  - When the write to ptr==DEPTH-1 completes, go to IDLE. CLEAR lasts exactly DEPTH cycles.
  - Loader inputs are ignored.
- **IDLE with load_start=1:**
  - rem is set to min(load_len, DEPTH), ptr=0, next state LOAD.
  - If load_len==0, stay in IDLE and pulse load_done the next cycle.
  - Memory is not cleared. Words at or above rem keep their prior contents.
- **LOAD:**
  - load_ready=1.
  - On load_valid && load_ready: mem[ptr] <= load_data, ptr++, rem--.
  - When the accepted word makes rem reach 0, go to IDLE and pulse load_done the next cycle.
  - Gaps in load_valid are allowed.
  - load_start is ignored.
- **Fetch:**
  - In IDLE with chip_select=1: data_out <= mem[address], data_valid <= 1.
  - Otherwise (chip_select=0, or state CLEAR/LOAD): data_out <= 0 (NOP), data_valid <= 0.
  - The CPU stalls while busy.
- Writes and reads are never concurrent because reads occur only in IDLE. No read-during-write case exists.

## Timing
- Fetch latency is 1 cycle: address sampled at edge N, data at edge N+1.
- A back-to-back fetch on every cycle sustains one word per cycle.
- busy falls on the edge where the state becomes IDLE. A fetch issued in that same cycle is valid.
- After a reset deassertion at edge 0, IDLE is reached at edge DEPTH, and the first valid data_out appears at edge DEPTH+1.
- Load throughput is one word per cycle while load_valid is held high.
- load_ready drops in the cycle after the last accepted word.
- load_done is high for exactly one cycle, coincident with the first IDLE cycle.

## Structure
- Package scic_pkg holds:
  - OPCODE constants (ADD=1, SL=2, SR=3, LI=4, LD=5, OR=6, ST=7, BR=8, AND=9)
  - NOP = '0
  - the instr_mem state enum (CLEAR/IDLE/LOAD)
- Sub-module scic_ram_sp:
  - single-port synchronous RAM, parameters DATA_WIDTH/ADDR_WIDTH
  - ports: clk, we, addr, wdata, rdata; no reset
- instr_mem muxes the RAM address between ptr (CLEAR/LOAD) and address (IDLE).

## Test plan
- **Reset then fetch:** reset high for 2 cycles, wait until busy=0, fetch addresses 0x00..0x1F → every data_out=0x0000_0000 with data_valid=1; busy was high for exactly 32 cycles.
- **Full load and fetch:**
  - Stimulus: load_start with load_len=21, then stream the 21-word self-test program (0x4000_000F, 0x7000_005F, …, 0x8000_0000).
  - Response: load_done pulses once.
  - Fetch 0x01 → 0x7000_005F; fetch 0x14 → 0x8000_0000; fetch 0x15 → 0.
- **Gapped load:** load_len=3, load_valid pattern 1,0,0,1,0,1 → exactly 3 writes at addresses 0..2; load_done on the cycle after the third accept.
- **Boundary lengths:**
  - load_len=0 → no write, load_done after 1 cycle.
  - load_len=40 on DEPTH=32 → clamped to 32 accepts; the 33rd beat is not accepted (load_ready=0).
- **Fetch blocked while busy:** chip_select=1 during LOAD → data_valid=0, data_out=0. chip_select=0 in IDLE → data_valid=0.
- **Reset mid-load:** reset after 5 of 10 words → no load_done; a CLEAR sweep runs; afterwards address 0x02 reads 0.

Source files
------------

// File: rtl/scic_pkg.sv
// rtl/scic_pkg.sv - shared SCIC constants, opcodes and instr_mem state encoding
package scic_pkg;

    // Opcodes occupy the top 4 bits of each instruction word
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SL  = 4'd2;
    localparam logic [3:0] OP_SR  = 4'd3;
    localparam logic [3:0] OP_LI  = 4'd4;
    localparam logic [3:0] OP_LD  = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_ST  = 4'd7;
    localparam logic [3:0] OP_BR  = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9;

    // An all-zero word decodes as a no-operation
    localparam logic [31:0] NOP = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/scic_ram_sp.sv
// rtl/scic_ram_sp.sv - single-port synchronous RAM without reset
module scic_ram_sp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Write when enabled; the read port always registers the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - self-clearing, stream-loadable instruction memory with registered fetch
module instr_mem
    import scic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_select,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  busy
);

    localparam int                    DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
    localparam logic [DATA_WIDTH-1:0] NOP_W    = DATA_WIDTH'(NOP);

    imem_state_e           state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  fetch_q;
    logic                  load_ready_q;
    logic                  load_done_q;
    logic                  busy_q;

    logic                  accept;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [ADDR_WIDTH:0]   len_clamped;

    // Port steering: the pointer owns the RAM in CLEAR/LOAD, the fetch address in IDLE
    always_comb begin
        accept      = (state_q == ST_LOAD) && load_valid;
        ram_we      = (state_q == ST_CLEAR) || accept;
        ram_addr    = (state_q == ST_IDLE) ? address : ptr_q;
        ram_wdata   = (state_q == ST_CLEAR) ? NOP_W : load_data;
        len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    end

    scic_ram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Clear/idle/load sequencer with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            rem_q        <= '0;
            fetch_q      <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            load_done_q <= 1'b0;
            fetch_q     <= (state_q == ST_IDLE) && chip_select;
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + PTR_ONE;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (load_start) begin
                        ptr_q <= '0;
                        if (load_len == '0) begin
                            load_done_q <= 1'b1;
                        end else begin
                            rem_q        <= len_clamped;
                            state_q      <= ST_LOAD;
                            load_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        ptr_q <= ptr_q + PTR_ONE;
                        rem_q <= rem_q - REM_ONE;
                        if (rem_q == REM_ONE) begin
                            state_q      <= ST_IDLE;
                            load_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            load_done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Non-fetch cycles present NOP so the CPU never sees stale RAM output
    assign data_out   = fetch_q ? ram_rdata : NOP_W;
    assign data_valid = fetch_q;
    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - randomized self-checking bench for instr_mem against an array model
module tb_instr_mem;
    import scic_pkg::*;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chip_select = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        load_start = 1'b0;
    logic [5:0]  load_len = '0;
    logic [31:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic        busy;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] load_words [64];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    instr_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .chip_select (chip_select),
        .address     (address),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Back-to-back fetch of every address, compared against the model
    task automatic fetch_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            address     = 5'(a);
            chip_select = 1'b1;
            step();
            check($sformatf("%s_data_%0d", tag, a), data_out, ref_mem[a]);
            check_bit($sformatf("%s_valid_%0d", tag, a), data_valid, 1'b1);
        end
        chip_select = 1'b0;
    endtask

    task automatic fetch_one(input string tag, input int a);
        address     = 5'(a);
        chip_select = 1'b1;
        step();
        check(tag, data_out, ref_mem[a]);
        check_bit({tag, "_valid"}, data_valid, 1'b1);
        chip_select = 1'b0;
    endtask

    // Count cycles until busy drops; returns -1 on timeout
    task automatic wait_idle(output int cycles, output logic saw_done);
        cycles   = 0;
        saw_done = 1'b0;
        while (busy && cycles < 200) begin
            step();
            cycles++;
            if (load_done) saw_done = 1'b1;
        end
        if (busy) cycles = -1;
    endtask

    // mode 0: valid held, 1: random gaps, 2: fixed 1,0,0,1,0,1 pattern
    task automatic do_load(input int len, input int mode, input int abort_after, output int cycles);
        int n;
        int acc;
        int cyc;
        logic v;
        int pat [6];
        pat = '{1, 0, 0, 1, 0, 1};
        n = (len > DEPTH) ? DEPTH : len;
        cycles = 0;
        load_len   = 6'(len);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        if (n == 0) begin
            check_bit("len0_done", load_done, 1'b1);
            check_bit("len0_busy", busy, 1'b0);
            check_bit("len0_ready", load_ready, 1'b0);
            step();
            check_bit("len0_done_clr", load_done, 1'b0);
            return;
        end
        check_bit("load_ready_up", load_ready, 1'b1);
        check_bit("load_busy_up", busy, 1'b1);
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 1000) begin
            if (abort_after >= 0 && acc == abort_after) begin
                reset      = 1'b1;
                load_valid = 1'b1;
                load_data  = load_words[acc];
                step();
                check_bit("abort_done", load_done, 1'b0);
                check_bit("abort_busy", busy, 1'b1);
                check_bit("abort_ready", load_ready, 1'b0);
                reset      = 1'b0;
                load_valid = 1'b0;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (cyc < 6) ? 1'(pat[cyc]) : 1'b1;
            endcase
            load_valid = v;
            load_data  = v ? load_words[acc] : 32'($urandom);
            if (cyc == 0) begin
                chip_select = 1'b1;
                address     = 5'd5;
            end
            step();
            if (cyc == 0) begin
                check_bit("fetch_in_load_valid", data_valid, 1'b0);
                check("fetch_in_load_data", data_out, 32'h0);
                chip_select = 1'b0;
            end
            cyc++;
            if (v) begin
                ref_mem[acc] = load_words[acc];
                acc++;
            end
            if (acc < n) begin
                check_bit("load_ready_hold", load_ready, 1'b1);
                check_bit("load_done_early", load_done, 1'b0);
            end
        end
        load_valid = 1'b0;
        cycles = cyc;
        if (acc < n) begin
            check_bit("load_timeout", 1'b1, 1'b0);
            return;
        end
        check_bit("load_done_pulse", load_done, 1'b1);
        check_bit("load_ready_drop", load_ready, 1'b0);
        check_bit("load_busy_drop", busy, 1'b0);
        if (len > DEPTH) begin
            // Extra beat offered after the clamp must not be taken
            load_valid = 1'b1;
            load_data  = 32'hDEAD_BEEF;
        end
        step();
        load_valid = 1'b0;
        check_bit("load_done_single", load_done, 1'b0);
        check_bit("load_ready_stays_low", load_ready, 1'b0);
    endtask

    initial begin
        int   cyc;
        logic saw_done;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset for two cycles, then observe the clear sweep
        reset = 1'b1;
        step();
        step();
        check("rst_data_out", data_out, 32'h0);
        check_bit("rst_valid", data_valid, 1'b0);
        check_bit("rst_ready", load_ready, 1'b0);
        check_bit("rst_done", load_done, 1'b0);
        check_bit("rst_busy", busy, 1'b1);
        reset = 1'b0;
        wait_idle(cyc, saw_done);
        check("clear_cycles", 32'(cyc), 32'd32);
        fetch_all("after_clear");

        // Self-test program: known first, second and last words, random middle
        load_words[0]  = {OP_LI, 28'h000000F};
        load_words[1]  = {OP_ST, 28'h000005F};
        for (int i = 2; i < 20; i++)
            load_words[i] = {4'($urandom_range(1, 9)), 28'($urandom)};
        load_words[20] = {OP_BR, 28'h0};
        do_load(21, 0, -1, cyc);
        check("full_load_cycles", 32'(cyc), 32'd21);
        fetch_one("fetch_01", 1);
        check("fetch_01_const", data_out, 32'h7000_005F);
        fetch_one("fetch_14", 20);
        check("fetch_14_const", data_out, 32'h8000_0000);
        fetch_one("fetch_15", 21);
        check("fetch_15_const", data_out, 32'h0);

        // Gapped 3-word load
        for (int i = 0; i < 3; i++) load_words[i] = 32'($urandom);
        do_load(3, 2, -1, cyc);
        check("gapped_cycles", 32'(cyc), 32'd6);
        fetch_all("after_gapped");

        // Zero-length load leaves memory untouched
        do_load(0, 0, -1, cyc);
        fetch_all("after_len0");

        // Oversized load clamps to DEPTH, with random gaps
        for (int i = 0; i < 40; i++) load_words[i] = 32'($urandom);
        do_load(40, 1, -1, cyc);
        fetch_all("after_clamp");

        // chip_select low in IDLE gives no fetch
        address     = 5'd3;
        chip_select = 1'b0;
        step();
        check_bit("cs_low_valid", data_valid, 1'b0);
        check("cs_low_data", data_out, 32'h0);

        // Reset after 5 of 10 words aborts the load and re-clears
        for (int i = 0; i < 10; i++) load_words[i] = 32'($urandom) | 32'h1;
        do_load(10, 0, 5, cyc);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        wait_idle(cyc, saw_done);
        check("abort_clear_cycles", 32'(cyc), 32'd32);
        check_bit("abort_no_done", saw_done, 1'b0);
        fetch_one("abort_fetch_02", 2);
        fetch_all("after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
